mem_sync_ctrl: RTL and testbench

//  Parametrised single-port data memory with a req/ready/done handshake, byte write

---
 rtl/mem_sync_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_sync_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_sync_ctrl
// Brief    : Single-port data memory with req/ready/done handshake, byte
//            enables, configurable completion latency and range checking.
// Revision : 1.0 - initial release
// ============================================================================
module mem_sync_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                WE,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   Data,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic                done,
  output logic [DATA_W-1:0]   MemOut,
  output logic                err
);

  localparam int              NBYTES   = DATA_W / 8;
  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] c_depth  = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      c_lat_m1 = 4'(RD_LAT - 1);
  localparam logic [0:0]      c_idle   = 1'b0;
  localparam logic [0:0]      c_wait   = 1'b1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [0:0]        r_state;
  logic [0:0]        w_next_state;
  logic [3:0]        r_cnt;
  logic              r_pend_we;
  logic              r_pend_err;
  logic [DATA_W-1:0] r_pend_data;
  logic              r_done;
  logic              r_err;
  logic [DATA_W-1:0] r_memout;
  logic              w_accept;
  logic              w_in_range;
  logic              w_finish_wait;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rd_data;

  assign w_accept      = req & ready;
  assign w_in_range    = ({1'b0, addr} < c_depth);
  assign w_idx         = addr[IDX_W-1:0];
  assign w_rd_data     = w_in_range ? r_mem[w_idx] : '0;
  assign w_finish_wait = (r_state == c_wait) && (r_cnt == 4'd1);

  assign done   = r_done;
  assign err    = r_err;
  assign MemOut = r_memout;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_idle;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:  if (w_accept && (RD_LAT > 1)) w_next_state = c_wait;
      c_wait:  if (r_cnt == 4'd1) w_next_state = c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  // Output logic: nothing is accepted while reset is asserted
  always_comb begin
    ready = (r_state == c_idle) && !rst;
  end

  // Read data and range status are captured at acceptance, presented at completion
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 4'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_memout    <= '0;
      r_pend_we   <= 1'b0;
      r_pend_err  <= 1'b0;
      r_pend_data <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_accept) begin
        r_pend_we   <= WE;
        r_pend_err  <= !w_in_range;
        r_pend_data <= w_rd_data;
        if (RD_LAT == 1) begin
          r_done <= 1'b1;
          r_err  <= !w_in_range;
          if (!WE) r_memout <= w_rd_data;
        end else begin
          r_cnt <= c_lat_m1;
        end
      end else if (w_finish_wait) begin
        r_done <= 1'b1;
        r_err  <= r_pend_err;
        r_cnt  <= 4'd0;
        if (!r_pend_we) r_memout <= r_pend_data;
      end else if (r_state == c_wait) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Array contents survive reset; writes land at the acceptance edge
  always_ff @(posedge clk) begin
    if (w_accept && WE && w_in_range) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (be[i]) r_mem[w_idx][8*i +: 8] <= Data[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_sync_ctrl
// Brief    : Self-checking bench for mem_sync_ctrl (RD_LAT=1 and RD_LAT=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_sync_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req1 = 1'b0;
  logic        req3 = 1'b0;
  logic        WE = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] Data = '0;
  logic [1:0]  be = '0;
  logic        ready1, done1, err1;
  logic        ready3, done3, err3;
  logic [15:0] memout1, memout3;

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] model_mem [2][256];
  logic [15:0] model_out [2];
  logic [15:0] pool [10] = '{16'h0000, 16'h0010, 16'h0020, 16'h0030, 16'h0040,
                             16'h0050, 16'h00FF, 16'h0100, 16'h0200, 16'hFFFF};

  always #5 clk = ~clk;

  mem_sync_ctrl #(.DATA_W(16), .DEPTH(256), .ADDR_W(16), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .WE(WE), .addr(addr), .Data(Data), .be(be),
    .ready(ready1), .done(done1), .MemOut(memout1), .err(err1)
  );

  mem_sync_ctrl #(.DATA_W(16), .DEPTH(256), .ADDR_W(16), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .WE(WE), .addr(addr), .Data(Data), .be(be),
    .ready(ready3), .done(done3), .MemOut(memout3), .err(err3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? ready1 : ready3;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel == 0) ? done1 : done3;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? err1 : err3;
  endfunction
  function automatic logic [15:0] get_out(input int sel);
    return (sel == 0) ? memout1 : memout3;
  endfunction

  // One request, checked for latency, ready during wait, err, MemOut and pulse width
  task automatic do_op(input int sel, input logic we, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] b);
    int   lat;
    int   exp_lat;
    logic exp_err;
    exp_lat = (sel == 0) ? 1 : 3;
    @(negedge clk);
    chk("ready_idle", get_ready(sel), 1'b1);
    WE = we; addr = a; Data = d; be = b;
    if (sel == 0) req1 = 1'b1; else req3 = 1'b1;
    @(posedge clk); #1;
    req1 = 1'b0; req3 = 1'b0;
    exp_err = (a >= 16'd256);
    if (!exp_err) begin
      if (we) begin
        for (int i = 0; i < 2; i++)
          if (b[i]) model_mem[sel][a[7:0]][8*i +: 8] = d[8*i +: 8];
      end else begin
        model_out[sel] = model_mem[sel][a[7:0]];
      end
    end else if (!we) begin
      model_out[sel] = 16'h0000;
    end
    lat = 1;
    while (!get_done(sel) && lat < 20) begin
      chk("ready_wait", get_ready(sel), 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("ready_done", get_ready(sel), 1'b1);
    chk("err", get_err(sel), exp_err);
    chk("memout", get_out(sel), model_out[sel]);
    @(posedge clk); #1;
    chk("done_pulse", get_done(sel), 1'b0);
    chk("err_idle", get_err(sel), 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    model_out[0] = '0;
    model_out[1] = '0;

    // Reset behaviour
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready1", ready1, 1'b0);
    chk("rst_ready3", ready3, 1'b0);
    chk("rst_done", {done1, done3}, 2'b00);
    chk("rst_err", {err1, err3}, 2'b00);
    chk("rst_out1", memout1, 16'h0000);
    chk("rst_out3", memout3, 16'h0000);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("post_rst_ready1", ready1, 1'b1);
    chk("post_rst_ready3", ready3, 1'b1);

    // Give every in-range pool address a known value in both memories
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < 7; p++)
        do_op(s, 1'b1, pool[p], 16'($urandom), 2'b11);

    // Basic write/read
    do_op(0, 1'b1, 16'h0010, 16'h00A5, 2'b11);
    do_op(0, 1'b0, 16'h0010, 16'h0000, 2'b00);
    chk("basic_read", memout1, 16'h00A5);

    // Byte enables
    do_op(0, 1'b1, 16'h0020, 16'hFFFF, 2'b11);
    do_op(0, 1'b1, 16'h0020, 16'h1234, 2'b01);
    do_op(0, 1'b1, 16'h0020, 16'hAAAA, 2'b00);
    do_op(0, 1'b0, 16'h0020, 16'h0000, 2'b11);
    chk("be_read", memout1, 16'hFF34);

    // Out of range
    do_op(0, 1'b1, 16'h0100, 16'hBEEF, 2'b11);
    do_op(0, 1'b0, 16'h0100, 16'h0000, 2'b11);
    do_op(0, 1'b0, 16'h0000, 16'h0000, 2'b11);

    // RD_LAT=3 with req held through WAIT
    @(negedge clk);
    WE = 1'b0; addr = 16'h0010; req3 = 1'b1;
    model_out[1] = model_mem[1][8'h10];
    @(posedge clk); #1;
    chk("hold_k1_ready", ready3, 1'b0);
    chk("hold_k1_done", done3, 1'b0);
    @(posedge clk); #1;
    chk("hold_k2_ready", ready3, 1'b0);
    chk("hold_k2_done", done3, 1'b0);
    @(posedge clk); #1;
    chk("hold_k3_ready", ready3, 1'b1);
    chk("hold_k3_done", done3, 1'b1);
    chk("hold_k3_out", memout3, model_out[1]);
    @(posedge clk); #1;
    req3 = 1'b0;
    chk("hold_k4_ready", ready3, 1'b0);
    chk("hold_k4_done", done3, 1'b0);
    @(posedge clk); #1;
    chk("hold_k5_done", done3, 1'b0);
    @(posedge clk); #1;
    chk("hold_k6_done", done3, 1'b1);
    @(posedge clk); #1;

    // rst and req together: request ignored
    @(negedge clk);
    rst = 1'b1; req1 = 1'b1; WE = 1'b1; addr = 16'h0040; Data = 16'hDEAD; be = 2'b11;
    @(posedge clk); #1;
    chk("rstreq_done", done1, 1'b0);
    chk("rstreq_ready", ready1, 1'b0);
    @(negedge clk);
    rst = 1'b0; req1 = 1'b0;
    model_out[0] = '0;
    model_out[1] = '0;
    do_op(0, 1'b0, 16'h0040, 16'h0000, 2'b11);

    // Reset during WAIT: write kept, no done
    @(negedge clk);
    WE = 1'b1; addr = 16'h0030; Data = 16'h5A5A; be = 2'b11; req3 = 1'b1;
    @(posedge clk); #1;
    req3 = 1'b0;
    chk("abort_accepted", ready3, 1'b0);
    model_mem[1][8'h30] = 16'h5A5A;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_out[0] = '0;
    model_out[1] = '0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("abort_no_done", done3, 1'b0);
    end
    do_op(1, 1'b0, 16'h0030, 16'h0000, 2'b11);
    chk("abort_write_kept", memout3, 16'h5A5A);

    // Randomized operations on both latencies
    for (int n = 0; n < 30; n++) begin
      do_op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            pool[$urandom_range(0, 9)], 16'($urandom), 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
